// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU opcode encoding and the architectural condition-flag layout.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_ORR = 3'd3,
    ALU_EOR = 3'd4,
    ALU_MOV = 3'd5,
    ALU_CMP = 3'd6,
    ALU_CMN = 3'd7
  } alu_op_e;

  // Bit order N,Z,V,C (3..0) matches the condition unit.
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

endpackage

// File: rtl/flag_calc.sv
// Combinational N/Z/V/C computation for the execute-stage ALU operation.
module flag_calc
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_res,
  input  flags_t           cur,
  output flags_t           nxt
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;

  always_comb begin
    sum  = {1'b0, op_a} + {1'b0, op_b};
    diff = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
    res  = alu_res;
    nxt  = cur;
    unique case (op)
      ALU_ADD, ALU_CMN: begin
        // CMN has no destination, so its N/Z come from the internal sum.
        if (op == ALU_CMN) res = sum[WIDTH-1:0];
        nxt.c = sum[WIDTH];
        nxt.v = (op_a[MSB] == op_b[MSB]) & (sum[MSB] != op_a[MSB]);
      end
      ALU_SUB, ALU_CMP: begin
        if (op == ALU_CMP) res = diff[WIDTH-1:0];
        nxt.c = diff[WIDTH];
        nxt.v = (op_a[MSB] != op_b[MSB]) & (diff[MSB] != op_a[MSB]);
      end
      default: ;
    endcase
    nxt.n = res[MSB];
    nxt.z = (res == '0);
  end

endmodule

// File: rtl/flag_unit.sv
// Architectural flag register plus a scoreboard of in-flight flag-setting instructions.
module flag_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fs_issue,
  input  logic             fs_wr,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_res,
  output logic             nflag,
  output logic             zflag,
  output logic             vflag,
  output logic             cflag,
  output logic             flags_ready,
  output logic             flag_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  flags_t        flags;
  flags_t        calc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          inc;
  logic          dec;
  logic          err_set;

  flag_calc #(.WIDTH(WIDTH)) u_calc (
    .op      (alu_op_e'(alu_op)),
    .op_a    (op_a),
    .op_b    (op_b),
    .alu_res (alu_res),
    .cur     (flags),
    .nxt     (calc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flags <= '0;
    else if (fs_wr && !stall) flags <= calc;
  end

  always_comb begin
    inc     = fs_issue & ~stall & ~flush;
    dec     = fs_wr & ~stall;
    cnt_nxt = cnt;
    err_set = 1'b0;
    if (inc && !dec) begin
      if (cnt == CW'(DEPTH)) err_set = 1'b1;
      else cnt_nxt = cnt + CW'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) err_set = 1'b1;
      else cnt_nxt = cnt - CW'(1);
    end
    // Everything still outstanding after this cycle's write is squashed.
    if (flush) cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      flag_err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (err_set) flag_err <= 1'b1;
    end
  end

  assign nflag       = flags.n;
  assign zflag       = flags.z;
  assign vflag       = flags.v;
  assign cflag       = flags.c;
  assign flags_ready = (cnt == '0);

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit (WIDTH=32, DEPTH=3).
module tb_flag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs_issue, fs_wr, stall, flush;
  logic [2:0]  alu_op;
  logic [31:0] op_a, op_b, alu_res;
  logic        nflag, zflag, vflag, cflag, flags_ready, flag_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  flag_unit #(.WIDTH(32), .DEPTH(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .fs_issue    (fs_issue),
    .fs_wr       (fs_wr),
    .stall       (stall),
    .flush       (flush),
    .alu_op      (alu_op),
    .op_a        (op_a),
    .op_b        (op_b),
    .alu_res     (alu_res),
    .nflag       (nflag),
    .zflag       (zflag),
    .vflag       (vflag),
    .cflag       (cflag),
    .flags_ready (flags_ready),
    .flag_err    (flag_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] nzvc();
    return {28'd0, nflag, zflag, vflag, cflag};
  endfunction

  task automatic idle();
    fs_issue = 0; fs_wr = 0; stall = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    idle();
    #3;
    check("rst_flags", nzvc(), 32'h0);
    check("rst_ready", {31'd0, flags_ready}, 32'd1);
    check("rst_err", {31'd0, flag_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic stl);
    alu_op = op; op_a = a; op_b = b; alu_res = r; fs_wr = 1; stall = stl;
    tick();
    fs_wr = 0; stall = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    alu_op = 3'd0; op_a = '0; op_b = '0; alu_res = '0;
    tick();
    // Reset with random activity on every input.
    rst = 1'b0;
    fs_issue = 1; fs_wr = 1;
    alu_op = 3'($urandom_range(0, 7)); op_a = $urandom(); op_b = $urandom(); alu_res = $urandom();
    tick();
    tick();
    check("rst_hold_flags", nzvc(), 32'h0);
    check("rst_hold_ready", {31'd0, flags_ready}, 32'd1);
    check("rst_hold_err", {31'd0, flag_err}, 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("idle_flags", nzvc(), 32'h0);

    // Flag computation; fs_wr at cnt==0 also sets the sticky error.
    alu(3'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
    check("add_ovf", nzvc(), 32'b1010);
    check("wr_at_zero_err", {31'd0, flag_err}, 32'd1);
    alu(3'd6, 32'd5, 32'd5, 32'hDEAD, 0);
    check("cmp_eq", nzvc(), 32'b0101);
    alu(3'd6, 32'd0, 32'd1, 32'h0, 0);
    check("cmp_lt", nzvc(), 32'b1000);
    alu(3'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0);
    check("sub_ovf", nzvc(), 32'b0011);
    alu(3'd2, 32'hF0, 32'h0F, 32'h0, 0);
    check("and_keep_cv", nzvc(), 32'b0111);
    alu(3'd2, 32'hF0, 32'hF0, 32'h8000_0000, 1);
    check("and_stalled", nzvc(), 32'b0111);
    alu(3'd5, 32'h0, 32'h8000_0000, 32'h8000_0000, 0);
    check("mov_neg", nzvc(), 32'b1011);
    alu(3'd7, 32'hFFFF_FFFF, 32'd1, 32'h1234, 0);
    check("cmn_zero", nzvc(), 32'b0101);
    tick();
    check("hold_flags", nzvc(), 32'b0101);
    check("err_sticky", {31'd0, flag_err}, 32'd1);

    // Scoreboard.
    do_reset();
    fs_issue = 1; stall = 1;
    tick();
    check("issue_stalled", {31'd0, flags_ready}, 32'd1);
    stall = 0;
    tick();
    check("issue1_ready", {31'd0, flags_ready}, 32'd0);
    tick();
    check("issue2_ready", {31'd0, flags_ready}, 32'd0);
    fs_wr = 1;
    tick();
    check("issue_wr_ready", {31'd0, flags_ready}, 32'd0);
    fs_issue = 0;
    tick();
    check("wr1_ready", {31'd0, flags_ready}, 32'd0);
    tick();
    check("wr2_ready", {31'd0, flags_ready}, 32'd1);
    fs_wr = 0;
    check("drain_no_err", {31'd0, flag_err}, 32'd0);
    fs_issue = 1;
    tick();
    tick();
    flush = 1;
    tick();
    check("flush_ready", {31'd0, flags_ready}, 32'd1);
    idle();
    check("flush_no_err", {31'd0, flag_err}, 32'd0);
    fs_wr = 1;
    tick();
    fs_wr = 0;
    check("flush_cnt_zero", {31'd0, flag_err}, 32'd1);

    // Overflow at DEPTH, saturation, then reset clears the sticky error.
    do_reset();
    fs_issue = 1;
    tick(); tick(); tick();
    check("full_no_err", {31'd0, flag_err}, 32'd0);
    tick();
    fs_issue = 0;
    check("ovf_err", {31'd0, flag_err}, 32'd1);
    fs_wr = 1;
    tick(); tick();
    check("sat_ready_2", {31'd0, flags_ready}, 32'd0);
    tick();
    fs_wr = 0;
    check("sat_ready_3", {31'd0, flags_ready}, 32'd1);
    tick();
    check("ovf_sticky", {31'd0, flag_err}, 32'd1);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
